// File: rtl/tlc_sched_pkg.sv
// Shared types and constants for the TLC5955 frame scheduler.
package tlc_sched_pkg;

    // Sequencer states: power-up control pair, then grayscale/latch/display forever.
    typedef enum logic [2:0] {
        StInit,
        StCfgShift,
        StCfgLat,
        StGsShift,
        StGsLat,
        StDisplay
    } sched_state_e;

    // shift_sel encoding seen by the bit-level shifter.
    localparam logic SEL_CTRL = 1'b1;
    localparam logic SEL_GS   = 1'b0;

    // The device needs its control latch written twice to take effect.
    localparam int unsigned CFG_WRITES = 2;
    localparam int unsigned CFG_WR_W   = 2;

    // True in the states that own the shifter handshake.
    function automatic logic is_shift_state(sched_state_e s);
        return (s == StCfgShift) || (s == StGsShift);
    endfunction

endpackage

// File: rtl/tlc_gsclk_gen.sv
// Grayscale clock generator for one display window.
// Produces GS_CYCLES rising edges of gsclk while run_i is high, starting low and
// ending high; done_o pulses in the last cycle so the sequencer can leave DISPLAY.
// blank_i pauses the window: gsclk is held low and the window position freezes.
module tlc_gsclk_gen #(
    parameter int unsigned GS_CYCLES = 65536,
    parameter int unsigned CNT_W     = 17
) (
    input  logic clk,
    input  logic rst,
    input  logic run_i,
    input  logic blank_i,
    output logic gsclk_o,
    output logic done_o
);

    localparam logic [CNT_W-1:0] LastRise = CNT_W'(GS_CYCLES - 1);

    logic             phase_q, phase_d;
    logic [CNT_W-1:0] rise_cnt_q, rise_cnt_d;
    logic             advance;

    // Next window position; a blanked cycle consumes no slot, which stretches the window.
    always_comb begin
        phase_d    = phase_q;
        rise_cnt_d = rise_cnt_q;
        done_o     = 1'b0;
        advance    = run_i & ~blank_i;
        if (!run_i) begin
            phase_d    = 1'b0;
            rise_cnt_d = '0;
        end else if (advance) begin
            if (!phase_q) begin
                phase_d = 1'b1;
            end else begin
                phase_d = 1'b0;
                if (rise_cnt_q == LastRise) begin
                    rise_cnt_d = '0;
                    done_o     = 1'b1;
                end else begin
                    rise_cnt_d = rise_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    // Window position registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q    <= 1'b0;
            rise_cnt_q <= '0;
        end else begin
            phase_q    <= phase_d;
            rise_cnt_q <= rise_cnt_d;
        end
    end

    // Blank gates the clock immediately so no partial high phase reaches the device.
    assign gsclk_o = phase_q & ~blank_i;

endmodule

// File: rtl/tlc5955_frame_sched.sv
// TLC5955 frame scheduler: runs the double control-latch write after reset, then loops
// grayscale shift -> latch -> display window, serving host control rewrites and bank
// swaps between windows. Optional build macro TLC_SCHED_BLANK_EN adds the blank input,
// which pauses the display window without affecting latching or shifting.
module tlc5955_frame_sched
    import tlc_sched_pkg::*;
#(
    parameter int unsigned GS_CYCLES = 65536,
    parameter int unsigned CNT_W     = 17
) (
    input  logic clk,
    input  logic rst,
    output logic shift_start,
    output logic shift_sel,
    input  logic shift_done,
    output logic lat,
    output logic gsclk,
    output logic front_bank,
    input  logic cfg_req,
    output logic cfg_ack,
    input  logic frame_req,
    output logic frame_ack
`ifdef TLC_SCHED_BLANK_EN
    ,
    input  logic blank
`endif
);

    sched_state_e        state_q, state_d;
    logic                started_q, started_d;
    logic                shift_start_q, shift_start_d;
    logic                shift_sel_q, shift_sel_d;
    logic                lat_q, lat_d;
    logic                cfg_ack_q, cfg_ack_d;
    logic                cfg_ack_dly_q;
    logic                frame_ack_q, frame_ack_d;
    logic                front_bank_q, front_bank_d;
    logic                cfg_pending_q, cfg_pending_d;
    logic                cfg_host_q, cfg_host_d;
    logic [CFG_WR_W-1:0] cfg_wr_q, cfg_wr_d;
    logic                frame_pending_q, frame_pending_d;
    logic                display_run;
    logic                win_done;
    logic                blank_int;
    logic                cfg_req_ok;

`ifdef TLC_SCHED_BLANK_EN
    assign blank_int = blank;
`else
    assign blank_int = 1'b0;
`endif

    assign display_run = (state_q == StDisplay);

    tlc_gsclk_gen #(
        .GS_CYCLES(GS_CYCLES),
        .CNT_W    (CNT_W)
    ) u_gsclk_gen (
        .clk    (clk),
        .rst    (rst),
        .run_i  (display_run),
        .blank_i(blank_int),
        .gsclk_o(gsclk),
        .done_o (win_done)
    );

    // A host request is ignored while its ack is on the wire and for one cycle after,
    // giving the requester time to drop the level.
    assign cfg_req_ok = cfg_req & ~cfg_pending_q & ~cfg_ack_q & ~cfg_ack_dly_q
                        & (state_q != StInit);

    // Sequencer next state and registered-output decode.
    always_comb begin
        state_d         = state_q;
        started_d       = 1'b0;
        shift_start_d   = 1'b0;
        shift_sel_d     = shift_sel_q;
        lat_d           = 1'b0;
        cfg_ack_d       = 1'b0;
        frame_ack_d     = 1'b0;
        front_bank_d    = front_bank_q;
        cfg_pending_d   = cfg_pending_q;
        cfg_host_d      = cfg_host_q;
        cfg_wr_d        = cfg_wr_q;
        frame_pending_d = frame_pending_q;

        case (state_q)
            StInit: begin
                // Power-up control pair is internal; nobody is owed an ack.
                cfg_pending_d = 1'b1;
                cfg_host_d    = 1'b0;
                cfg_wr_d      = '0;
                state_d       = StCfgShift;
            end

            StCfgShift, StGsShift: begin
                started_d = 1'b1;
                if (!started_q) begin
                    shift_start_d = 1'b1;
                    shift_sel_d   = (state_q == StCfgShift) ? SEL_CTRL : SEL_GS;
                end else if (shift_done) begin
                    // Latch effects are committed here so they show alongside lat.
                    lat_d = 1'b1;
                    if (state_q == StCfgShift) begin
                        state_d = StCfgLat;
                        if (cfg_wr_q == CFG_WR_W'(CFG_WRITES - 1)) begin
                            cfg_wr_d      = '0;
                            cfg_pending_d = 1'b0;
                            cfg_ack_d     = cfg_host_q;
                            cfg_host_d    = 1'b0;
                        end else begin
                            cfg_wr_d = cfg_wr_q + CFG_WR_W'(1);
                        end
                    end else begin
                        state_d = StGsLat;
                        if (frame_pending_q) begin
                            front_bank_d    = ~front_bank_q;
                            frame_ack_d     = 1'b1;
                            frame_pending_d = 1'b0;
                        end
                    end
                end
            end

            StCfgLat: begin
                // Write counter wraps to zero once the pair is complete.
                state_d = (cfg_wr_q == '0) ? StGsShift : StCfgShift;
            end

            StGsLat: begin
                state_d = StDisplay;
            end

            StDisplay: begin
                if (win_done) begin
                    state_d = cfg_pending_q ? StCfgShift : StGsShift;
                end
            end

            default: begin
                state_d = StInit;
            end
        endcase

        // Requests are captured last so a pulse coinciding with a swap is not lost.
        if (frame_req) begin
            frame_pending_d = 1'b1;
        end
        if (cfg_req_ok) begin
            cfg_pending_d = 1'b1;
            cfg_host_d    = 1'b1;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= StInit;
            started_q       <= 1'b0;
            shift_start_q   <= 1'b0;
            shift_sel_q     <= 1'b0;
            lat_q           <= 1'b0;
            cfg_ack_q       <= 1'b0;
            cfg_ack_dly_q   <= 1'b0;
            frame_ack_q     <= 1'b0;
            front_bank_q    <= 1'b0;
            cfg_pending_q   <= 1'b0;
            cfg_host_q      <= 1'b0;
            cfg_wr_q        <= '0;
            frame_pending_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            started_q       <= started_d && is_shift_state(state_q);
            shift_start_q   <= shift_start_d;
            shift_sel_q     <= shift_sel_d;
            lat_q           <= lat_d;
            cfg_ack_q       <= cfg_ack_d;
            cfg_ack_dly_q   <= cfg_ack_q;
            frame_ack_q     <= frame_ack_d;
            front_bank_q    <= front_bank_d;
            cfg_pending_q   <= cfg_pending_d;
            cfg_host_q      <= cfg_host_d;
            cfg_wr_q        <= cfg_wr_d;
            frame_pending_q <= frame_pending_d;
        end
    end

    assign shift_start = shift_start_q;
    assign shift_sel   = shift_sel_q;
    assign lat         = lat_q;
    assign cfg_ack     = cfg_ack_q;
    assign frame_ack   = frame_ack_q;
    assign front_bank  = front_bank_q;

endmodule

// File: tb/tb_tlc5955_frame_sched.sv
// Scoreboard bench for tlc5955_frame_sched: a transaction-level model pushes the expected
// shift/latch/window events, a monitor pops and compares as the DUT presents them.
module tb_tlc5955_frame_sched;

    localparam int GS = 4;
    localparam int CW = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic shift_done = 1'b0;
    logic cfg_req = 1'b0;
    logic frame_req = 1'b0;
`ifdef TLC_SCHED_BLANK_EN
    logic blank = 1'b0;
`endif
    logic shift_start, shift_sel, lat, gsclk, front_bank, cfg_ack, frame_ack;

    always #5 clk = ~clk;

    tlc5955_frame_sched #(
        .GS_CYCLES(GS),
        .CNT_W    (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .shift_start(shift_start),
        .shift_sel  (shift_sel),
        .shift_done (shift_done),
        .lat        (lat),
        .gsclk      (gsclk),
        .front_bank (front_bank),
        .cfg_req    (cfg_req),
        .cfg_ack    (cfg_ack),
        .frame_req  (frame_req),
        .frame_ack  (frame_ack)
`ifdef TLC_SCHED_BLANK_EN
        ,
        .blank      (blank)
`endif
    );

    // Expected event: kind 0 = shift_start, 1 = lat, 2 = completed display window.
    typedef struct {
        int kind;
        int sel;
        int cack;
        int fack;
        int bank;
        int gap;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model state (stimulus side only).
    int m_bank = 0;
    int m_cfg = 0;
    int m_frame = 0;
    bit fixed_delay = 1'b1;

    // Monitor state.
    bit   rst_seen = 1'b0;
    bit   in_win = 1'b0;
    int   gap = 0;
    int   rises = 0;
    bit   gs_prev = 1'b0;
    bit   done_prev = 1'b0;
    int   cold = -1;
    int   idle = 0;
    int   last_sel = 0;
    exp_t e;
    bit   ok;

    int sh_d;

    task automatic chk(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: actual %0d required %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic pop_exp(output exp_t x, output bit got);
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL scoreboard: unexpected DUT event, actual 1 required 0 at %0t", $time);
            x   = '{default: 0};
            got = 1'b0;
        end else begin
            x   = exp_q.pop_front();
            got = 1'b1;
        end
    endtask

    task automatic push(input int kind, input int sel, input int cack, input int fack,
                        input int bank, input int gp);
        exp_t x;
        x = '{kind: kind, sel: sel, cack: cack, fack: fack, bank: bank, gap: gp};
        exp_q.push_back(x);
    endtask

    // Cold start: control written twice (no ack owed), then the first grayscale word.
    task automatic push_cold();
        push(0, 1, 0, 0, 0, 0);
        push(1, 0, 0, 0, 0, 0);
        push(0, 1, 0, 0, 0, 0);
        push(1, 0, 0, 0, 0, 0);
        push(0, 0, 0, 0, 0, 0);
        push(1, 0, 0, 0, 0, 0);
    endtask

    // Advance to the next grayscale latch; the host drops cfg_req once it sees the ack.
    task automatic wait_gs_lat();
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (cfg_ack) cfg_req = 1'b0;
            if (lat && !shift_sel) break;
        end
    endtask

    // One display window with optional requests; called with the DUT in its GS latch cycle.
    task automatic run_window(input bit do_cfg, input int nframe, input int nblank,
                              input bit same);
        int oc, f1, f2;
        oc = $urandom_range(0, 4);
        f1 = same ? oc : $urandom_range(0, 4);
        f2 = f1 + 1 + $urandom_range(0, 1);
        if (nframe > 0) m_frame = 1;
        if (do_cfg) m_cfg = 1;
        // Window: lat, 2*GS display cycles plus blanked ones, shift entry, then start.
        push(2, 0, 0, 0, 0, 2 * GS + nblank + 2);
        if (m_cfg != 0) begin
            push(0, 1, 0, 0, 0, 0);
            push(1, 0, 0, 0, m_bank, 0);
            push(0, 1, 0, 0, 0, 0);
            push(1, 0, 1, 0, m_bank, 0);
            m_cfg = 0;
        end
        push(0, 0, 0, 0, 0, 0);
        if (m_frame != 0) begin
            m_bank  = 1 - m_bank;
            m_frame = 0;
            push(1, 0, 0, 1, m_bank, 0);
        end else begin
            push(1, 0, 0, 0, m_bank, 0);
        end
        for (int k = 0; k < 7; k++) begin
            @(posedge clk);
            #1;
            if (do_cfg && k == oc) cfg_req = 1'b1;
            frame_req = (nframe >= 1 && k == f1) || (nframe >= 2 && k == f2);
`ifdef TLC_SCHED_BLANK_EN
            blank = (k >= 2) && (k < 2 + nblank);
`endif
        end
        @(posedge clk);
        #1;
        frame_req = 1'b0;
`ifdef TLC_SCHED_BLANK_EN
        blank = 1'b0;
`endif
        wait_gs_lat();
    endtask

    // Reset while gsclk is high in a window showing bank 1, then expect a clean cold start.
    task automatic reset_mid_window();
        if (m_bank == 0) run_window(1'b0, 1, 0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (gsclk) break;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        m_bank  = 0;
        m_cfg   = 0;
        m_frame = 0;
        push_cold();
        wait_gs_lat();
    endtask

    // Shifter model: answers each shift_start with a one-cycle shift_done.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (shift_start && !rst) begin
                sh_d = fixed_delay ? 3 : int'($urandom_range(1, 5));
                repeat (sh_d) begin
                    @(posedge clk);
                    #1;
                end
                shift_done = 1'b1;
                @(posedge clk);
                #1;
                shift_done = 1'b0;
            end
        end
    end

    // Monitor: sample mid-cycle, pop expectations as events appear.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                rst_seen  = 1'b1;
                in_win    = 1'b0;
                done_prev = 1'b0;
                gs_prev   = 1'b0;
                idle      = 0;
                cold      = -1;
                continue;
            end
            if (rst_seen) begin
                rst_seen = 1'b0;
                chk("reset gsclk", int'(gsclk), 0);
                chk("reset lat", int'(lat), 0);
                chk("reset front_bank", int'(front_bank), 0);
                chk("reset shift_start", int'(shift_start), 0);
                cold = 0;
            end else if (cold >= 0) begin
                cold++;
            end
            if (in_win) begin
                gap++;
                if (gsclk && !gs_prev) rises++;
            end
            if (shift_start) begin
                if (cold >= 0) begin
                    chk("cold-start latency", cold, 2);
                    cold = -1;
                end
                if (in_win) begin
                    pop_exp(e, ok);
                    if (ok) begin
                        chk("order window", 2, e.kind);
                        chk("window length", gap, e.gap);
                        chk("gsclk rises", rises, GS);
                    end
                    in_win = 1'b0;
                end
                pop_exp(e, ok);
                if (ok) begin
                    chk("order shift_start", 0, e.kind);
                    chk("shift_sel", int'(shift_sel), e.sel);
                    last_sel = e.sel;
                end
            end
            if (shift_done) chk("shift_sel held", int'(shift_sel), last_sel);
            if (lat || done_prev) chk("lat after shift_done", int'(lat), int'(done_prev));
            if (lat) begin
                pop_exp(e, ok);
                if (ok) begin
                    chk("order lat", 1, e.kind);
                    chk("cfg_ack", int'(cfg_ack), e.cack);
                    chk("frame_ack", int'(frame_ack), e.fack);
                    chk("front_bank", int'(front_bank), e.bank);
                end
                if (!shift_sel) begin
                    in_win = 1'b1;
                    gap    = 0;
                    rises  = 0;
                end
                idle = 0;
            end else begin
                if (cfg_ack || frame_ack) chk("ack without lat", int'(lat), 1);
                idle++;
                if (idle == 100) chk("watchdog lat", 0, 1);
            end
            gs_prev   = gsclk;
            done_prev = shift_done;
        end
    end

    // Stimulus.
    initial begin
        int do_cfg, nfr, nbl, same;
        push_cold();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        wait_gs_lat();
        run_window(1'b0, 0, 0, 1'b0);
        run_window(1'b0, 1, 0, 1'b0);
        run_window(1'b1, 1, 0, 1'b1);
        run_window(1'b0, 2, 0, 1'b0);
`ifdef TLC_SCHED_BLANK_EN
        run_window(1'b0, 0, 5, 1'b0);
`endif
        reset_mid_window();
        fixed_delay = 1'b0;
        for (int n = 0; n < 25; n++) begin
            do_cfg = ($urandom_range(0, 3) == 0) ? 1 : 0;
            nfr    = $urandom_range(0, 2);
            same   = $urandom_range(0, 1);
`ifdef TLC_SCHED_BLANK_EN
            nbl    = $urandom_range(0, 5);
`else
            nbl    = 0;
`endif
            run_window(do_cfg != 0, nfr, nbl, same != 0);
        end
        repeat (5) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
